// File: rtl/in_port_pack_if.sv
// in_port_pack_if: pixel stream in, packed FIFO write out
interface in_port_pack_if #(
  parameter int DSIZE = 24,
  parameter int PACK  = 4
);
  logic                  falign;
  logic                  lalign;
  logic                  ealign;
  logic                  idata_vld;
  logic [DSIZE-1:0]      idata;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DSIZE*PACK-1:0] fifo_wdata;
  logic [4:0]            fifo_wcnt;
  logic                  fifo_wsof;
  logic                  fifo_weof;
  modport master (
    output falign, lalign, ealign, idata_vld, idata, fifo_full,
    input  fifo_wr_en, fifo_wdata, fifo_wcnt, fifo_wsof, fifo_weof
  );
  modport slave (
    input  falign, lalign, ealign, idata_vld, idata, fifo_full,
    output fifo_wr_en, fifo_wdata, fifo_wcnt, fifo_wsof, fifo_weof
  );
endinterface

// File: rtl/in_port_pack.sv
// in_port_pack: packs PACK pixels per FIFO word with sof/eof framing and drop accounting (IN_PORT_PACK_LINE_FLUSH_EN flushes at every lalign)
module in_port_pack #(
  parameter int DSIZE = 24,
  parameter int PACK  = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  in_port_pack_if.slave bus,
  output logic          overflow,
  output logic [15:0]   drop_cnt
);
  typedef enum logic {WAIT_SOF, PACKING} state_t;
  state_t                state, state_nx;
  logic [4:0]            idx, idx_nx, nidx, lane, wcnt_nx;
  logic [DSIZE*PACK-1:0] lanes, lanes_nx, word, wdata_nx;
  logic                  sof_pend, sof_nx, wsof_nx, weof_nx;
  logic                  start, take, trunc, done, lflush, emit, write;
  logic [1:0]            drops;
  logic [16:0]           drop_sum;
`ifdef IN_PORT_PACK_LINE_FLUSH_EN
  assign lflush = bus.lalign;
`else
  assign lflush = 1'b0;
`endif
  // Next-state and word assembly; a truncating falign that also closes its own
  // one-pixel word would need two writes in one cycle, so that second word is dropped and counted
  always_comb begin
    start    = bus.idata_vld && bus.falign;
    take     = bus.idata_vld && (state == PACKING || bus.falign);
    trunc    = start && state == PACKING && idx != 5'd0;
    lane     = start ? 5'd0 : idx;
    nidx     = lane + 5'd1;
    word     = start ? '0 : lanes;
    word[lane*DSIZE +: DSIZE] = bus.idata;
    done     = take && (nidx == 5'(PACK) || bus.ealign || lflush);
    emit     = trunc || done;
    write    = emit && !bus.fifo_full;
    drops    = {1'b0, emit && bus.fifo_full} + {1'b0, trunc && done};
    drop_sum = {1'b0, drop_cnt} + 17'(drops);
    wdata_nx = trunc ? lanes : word;
    wcnt_nx  = trunc ? idx : nidx;
    wsof_nx  = trunc ? sof_pend : (start || sof_pend);
    weof_nx  = trunc || bus.ealign;
    lanes_nx = done ? '0 : take ? word : lanes;
    idx_nx   = done ? 5'd0 : take ? nidx : idx;
    sof_nx   = done ? 1'b0 : take ? (start || sof_pend) : sof_pend;
    state_nx = (take && bus.ealign) ? WAIT_SOF : start ? PACKING : state;
  end
  // Frame-sync state register
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= WAIT_SOF;
    else state <= state_nx;
  // Lane storage, registered FIFO write and sticky overflow accounting
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      lanes          <= '0;
      idx            <= '0;
      sof_pend       <= 1'b0;
      bus.fifo_wr_en <= 1'b0;
      bus.fifo_wdata <= '0;
      bus.fifo_wcnt  <= '0;
      bus.fifo_wsof  <= 1'b0;
      bus.fifo_weof  <= 1'b0;
      overflow       <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      lanes          <= lanes_nx;
      idx            <= idx_nx;
      sof_pend       <= sof_nx;
      bus.fifo_wr_en <= write;
      if (write) begin
        bus.fifo_wdata <= wdata_nx;
        bus.fifo_wcnt  <= wcnt_nx;
        bus.fifo_wsof  <= wsof_nx;
        bus.fifo_weof  <= weof_nx;
      end
      if (drops != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
endmodule

// File: tb/tb_in_port_pack.sv
// tb_in_port_pack: randomized scoreboard bench for in_port_pack against a pixel-list frame model
module tb_in_port_pack;
  localparam int DSIZE = 24;
  localparam int PACK  = 4;
`ifdef IN_PORT_PACK_LINE_FLUSH_EN
  localparam bit LF = 1'b1;
`else
  localparam bit LF = 1'b0;
`endif
  typedef struct {
    logic [DSIZE*PACK-1:0] data;
    int                    cnt;
    bit                    sof;
    bit                    eof;
    longint                cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        overflow;
  logic [15:0] drop_cnt;
  longint      cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  logic [DSIZE-1:0] cur[$];
  bit          in_frame = 1'b0;
  bit          cur_sof = 1'b0;
  int          exp_drop = 0;
  int          n_emit = 0;

  in_port_pack_if #(.DSIZE(DSIZE), .PACK(PACK)) bus ();

  in_port_pack #(.DSIZE(DSIZE), .PACK(PACK)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .bus      (bus),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // A finished word: the first one in a cycle goes to the FIFO unless it is full,
  // any further word in the same cycle is lost and counted.
  function automatic void emit(input bit eof);
    exp_t w;
    w.data = '0;
    foreach (cur[i]) w.data[i*DSIZE +: DSIZE] = cur[i];
    w.cnt = cur.size();
    w.sof = cur_sof;
    w.eof = eof;
    w.cyc = cyc + 1;
    if (n_emit == 0 && !bus.fifo_full) sbq.push_back(w);
    else if (exp_drop < 65535) exp_drop++;
    n_emit++;
    cur.delete();
    cur_sof = 1'b0;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.idata_vld = 1'b0;
      bus.idata  = DSIZE'($urandom);
      bus.falign = 1'($urandom);
      bus.lalign = 1'($urandom);
      bus.ealign = 1'($urandom);
      @(posedge clock); #1;
    end
  endtask

  task automatic pix(input logic [DSIZE-1:0] d, input bit f, input bit l, input bit e);
    bus.idata_vld = 1'b1;
    bus.idata  = d;
    bus.falign = f;
    bus.lalign = l;
    bus.ealign = e;
    n_emit = 0;
    if (f) begin
      if (in_frame && cur.size() > 0) emit(1'b1);
      in_frame = 1'b1;
      cur_sof  = 1'b1;
    end
    if (in_frame) begin
      cur.push_back(d);
      if (cur.size() == PACK || e || (LF && l)) emit(e);
      if (e) in_frame = 1'b0;
    end
    @(posedge clock); #1;
    bus.idata_vld = 1'b0;
    bus.falign = 1'b0;
    bus.lalign = 1'b0;
    bus.ealign = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes still pending, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 128'(bus.fifo_wr_en), 128'd0);
    chk({tag, "_wdata"}, 128'(bus.fifo_wdata), 128'd0);
    chk({tag, "_wcnt"},  128'(bus.fifo_wcnt),  128'd0);
    chk({tag, "_wsof"},  128'(bus.fifo_wsof),  128'd0);
    chk({tag, "_weof"},  128'(bus.fifo_weof),  128'd0);
    chk({tag, "_ovf"},   128'(overflow),       128'd0);
    chk({tag, "_drop"},  128'(drop_cnt),       128'd0);
  endtask

  // Monitor: every DUT write is matched in order against the scoreboard
  always @(negedge clock) begin
    if (rst_n && bus.fifo_wr_en) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: wdata %0h with nothing expected", bus.fifo_wdata);
      end else begin
        exp_t w;
        w = sbq.pop_front();
        chk("wdata", 128'(bus.fifo_wdata), 128'(w.data));
        chk("wcnt",  128'(bus.fifo_wcnt),  128'(w.cnt));
        chk("wsof",  128'(bus.fifo_wsof),  128'(w.sof));
        chk("weof",  128'(bus.fifo_weof),  128'(w.eof));
        chk("latency_cycle", 128'(cyc), 128'(w.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.idata_vld = 1'b0;
    bus.idata     = '0;
    bus.falign    = 1'b0;
    bus.lalign    = 1'b0;
    bus.ealign    = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clock); #1;

    // Two lines of 6 pixels, data 1..12
    for (int i = 1; i <= 12; i++)
      pix(DSIZE'(i), i == 1, i % 6 == 0, i == 12);
    idle(2);
    drain();

    // Pre-frame pixels are ignored, then a 4-pixel frame
    for (int i = 0; i < 5; i++) pix(DSIZE'(32'h100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pix(DSIZE'(32'h200 + i), i == 0, 1'b0, i == 3);
    idle(2);
    drain();

    // Single-pixel frame
    pix(24'hABCDEF, 1'b1, 1'b0, 1'b1);
    idle(2);
    drain();

    // Two words dropped while full, then a normal write
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 8; i++) pix(DSIZE'(32'h300 + i), i == 0, 1'b0, 1'b0);
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) pix(DSIZE'(32'h400 + i), i == 0, 1'b0, i == 3);
    idle(2);
    drain();
    chk("drop_cnt_after_full", 128'(drop_cnt), 128'd2);
    chk("overflow_after_full", 128'(overflow), 128'd1);

    // Reset in the middle of a frame
    pix(24'h500, 1'b1, 1'b0, 1'b0);
    pix(24'h501, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("midreset");
    cur.delete();
    in_frame = 1'b0;
    cur_sof  = 1'b0;
    exp_drop = 0;
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) pix(DSIZE'(32'h600 + i), i == 0, 1'b0, i == 3);
    idle(2);
    drain();

    // Random traffic with gaps, stray markers, truncations and back-pressure
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else begin
        bus.fifo_full = ($urandom_range(9) == 0);
        pix(DSIZE'($urandom), $urandom_range(15) == 0, $urandom_range(4) == 0,
            $urandom_range(19) == 0);
      end
    end
    bus.fifo_full = 1'b0;
    idle(3);
    drain();
    chk("final_drop_cnt", 128'(drop_cnt), 128'(exp_drop));
    chk("final_overflow", 128'(overflow), 128'(exp_drop > 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/in_port_pack.md
# in_port_pack

Packs the pixel stream produced by the video input port (`falign`/`lalign`/`ealign` markers, `odata_vld`/`odata` data) into wide words of `PACK` pixels and writes them into the VDMA write-side FIFO. It sits directly downstream of the input port and upstream of the AXI write burst generator. It provides frame synchronisation, end-of-line/end-of-frame flushing and overflow accounting.

## Interface
- `DSIZE`, 24, pixel width in bits
- `PACK`, 4, pixels per output word (2..16)

- `clock` in 1 — single clock domain
- `rst_n` in 1 — reset, asynchronous assert, active-low
- `falign` in 1 — first-pixel-of-frame marker, qualified by `idata_vld`
- `lalign` in 1 — last-pixel-of-line marker, qualified by `idata_vld`
- `ealign` in 1 — last-pixel-of-frame marker, qualified by `idata_vld`
- `idata_vld` in 1 — pixel valid
- `idata` in DSIZE — pixel data
- `fifo_full` in 1 — FIFO cannot accept a write this cycle
- `fifo_wr_en` out 1 — FIFO write strobe
- `fifo_wdata` out DSIZE*PACK — packed word; pixel 0 in the LSBs
- `fifo_wcnt` out 5 — number of valid pixels in the word (1..PACK)
- `fifo_wsof` out 1 — word holds the first pixel of a frame
- `fifo_weof` out 1 — word holds the last pixel of a frame
- `overflow` out 1 — sticky flag; at least one word was dropped
- `drop_cnt` out 16 — dropped-word count, saturates at 0xFFFF

## Operation
- FSM has two states.
  - `WAIT_SOF` (reset state): pixels are discarded until `idata_vld && falign`. That pixel goes to lane 0, and the FSM moves to `PACK`.
  - `PACK`: each valid pixel is written to lane `idx`, and `idx` increments. The word is emitted when any of these holds:
    - `idx` reaches `PACK`
    - `ealign` is seen
    - `lalign` is seen (only when the macro is enabled)
  - After the word is emitted, `idx` returns to 0.
  - `ealign` returns the FSM to `WAIT_SOF`.
- Unused lanes of a partial word are zero. `fifo_wcnt` equals the pixel count.
- `fifo_wsof` is 1 only on the word containing the `falign` pixel. `fifo_weof` is 1 only on the word containing the `ealign` pixel.
- Same-cycle `falign` and `ealign` (single-pixel frame): one word is emitted with `wcnt=1`, `wsof=1`, `weof=1`. The FSM ends in `WAIT_SOF`.
- `falign` arriving while in `PACK` (truncated frame):
  - If `idx>0`, the pending partial word is emitted with `weof=1`.
  - The new pixel starts a fresh word in lane 0, flagged as sof.
  - The FSM stays in `PACK`.
- Overflow: a word due for emission while `fifo_full=1` is dropped, not stalled. In that case:
  - `fifo_wr_en` stays 0.
  - `drop_cnt` increments (saturating).
  - `overflow` sets.
  - Lane state resets exactly as for a successful write.
- `overflow` and `drop_cnt` clear only on reset.
- Reset mid-frame discards the partial word and returns the FSM to `WAIT_SOF`.

## Timing
- All outputs are registered. Reset values are 0 for `fifo_wr_en`, `fifo_wdata`, `fifo_wcnt`, `fifo_wsof`, `fifo_weof`, `overflow` and `drop_cnt`.
- Latency: `fifo_wr_en` pulses 1 cycle after the pixel that completes or flushes the word.
- `fifo_full` is sampled in the same cycle as that completing pixel.
- `fifo_wr_en` is a single-cycle pulse. Output fields are valid only while it is high and hold their values otherwise.
- At most one write per cycle. Back-to-back writes are possible when `PACK` pixels arrive every cycle.
- Gaps in `idata_vld` are allowed. Markers and data without `idata_vld` are ignored.

## Configuration
- `IN_PORT_PACK_LINE_FLUSH_EN` defined:
  - A word is flushed at every `lalign`, so every line starts in lane 0. Suited to `LINE` mode line-addressed writes.
- Not defined:
  - `lalign` is ignored. Lines pack contiguously and only `ealign` flushes a partial word. Suited to `ONCE` mode frame-linear writes.

## Test plan
- `PACK=4`, one frame with 2 lines of 6 px, data 1..12, macro off:
  - 3 writes of 4 px each.
  - The first write has `wsof=1`; the third has `weof=1`; all have `wcnt=4`.
- Same stimulus with macro on:
  - Per line, 1 write with `wcnt=4`, then 1 with `wcnt=2` and lanes 2/3 zero.
  - 4 writes in total; `weof=1` on the 4th.
- 5 valid pixels before the first `falign`, then a 4-px frame:
  - Pre-frame pixels are discarded.
  - Single write of pixels 0..3 with `wsof=1`, `weof=1`.
- Single pixel with `falign=ealign=1`, data 0xABCDEF:
  - One write with `wdata[23:0]=0xABCDEF`, `wcnt=1`, `wsof=1`, `weof=1`.
- `fifo_full=1` held across 2 word completions:
  - No `fifo_wr_en`.
  - `drop_cnt=2`, `overflow=1`.
  - The next word after `fifo_full` drops is written normally; `overflow` stays 1.
- `rst_n` pulsed low after 2 px of a frame, then a new frame is sent:
  - Outputs read 0 during reset.
  - The first write after reset has `wsof=1` and contains only new-frame data.
